// File: rtl/fibo_ctrl_pkg.sv
// Shared definitions for the Fibonacci sequencer control slice:
// state encodings and default parameter values.
package fibo_ctrl_pkg;

  localparam int DATAWIDTH_BUS_DEF = 8;
  localparam int COUNTWIDTH_DEF    = 5;
  localparam int PACE_CYCLES_DEF   = 50000000;
  localparam int PACEWIDTH_DEF     = 26;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_PACE = 3'd2,
    S_STEP      = 3'd3,
    S_DONE      = 3'd4,
    S_OVF       = 3'd5
  } fibo_state_e;

endpackage

// File: rtl/fibo_sequencer_ctrl_if.sv
// Handshake between the sequencer control unit (slave) and the
// board/datapath side (master) that drives start, target and carry.
interface fibo_sequencer_ctrl_if #(
  parameter int COUNTWIDTH = 5
);
  logic                  start_InHigh;
  logic [COUNTWIDTH-1:0] n_target_InBUS;
  logic                  carry_In;
  logic                  load_seed_Out;
  logic                  shift_Out;
  logic                  busy_Out;
  logic                  done_Out;
  logic                  overflow_Out;
  logic [COUNTWIDTH-1:0] index_OutBUS;

  modport slave (
    input  start_InHigh, n_target_InBUS, carry_In,
    output load_seed_Out, shift_Out, busy_Out, done_Out, overflow_Out, index_OutBUS
  );

  modport master (
    output start_InHigh, n_target_InBUS, carry_In,
    input  load_seed_Out, shift_Out, busy_Out, done_Out, overflow_Out, index_OutBUS
  );
endinterface

// File: rtl/fibo_pace_timer.sv
// Step pacing counter: counts while enabled, ticks on the last cycle of
// each PACE_CYCLES window and wraps to zero on that tick.
module fibo_pace_timer #(
  parameter int PACE_CYCLES = 50000000,
  parameter int PACEWIDTH   = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [PACEWIDTH-1:0] cnt_q;
  logic [PACEWIDTH-1:0] cnt_d;

  assign tick = en & (cnt_q == PACEWIDTH'(PACE_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PACEWIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fibo_sequencer_ctrl.sv
// Fibonacci datapath control: seeds RegA/RegB on a start edge, then issues
// paced shift steps until the target count is reached or the adder carries.
module fibo_sequencer_ctrl
  import fibo_ctrl_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int COUNTWIDTH    = COUNTWIDTH_DEF,
  parameter int PACE_CYCLES   = PACE_CYCLES_DEF,
  parameter int PACEWIDTH     = PACEWIDTH_DEF
) (
  input  logic                  SC_RegFIXED_CLOCK_50,
  input  logic                  SC_RegFIXED_RESET_InHigh,
  fibo_sequencer_ctrl_if.slave  bus
);

  if (DATAWIDTH_BUS < 1 || PACE_CYCLES < 1 || ((PACE_CYCLES - 1) >> PACEWIDTH) != 0) begin : g_bad_params
    $error("fibo_sequencer_ctrl: illegal parameter combination");
  end

  fibo_state_e           state_q, state_d;
  logic [COUNTWIDTH-1:0] target_q, target_d;
  logic [COUNTWIDTH-1:0] index_q, index_d;
  logic                  start_q;
  logic                  load_seed_q, busy_q, done_q, overflow_q;
  logic                  start_rise;
  logic                  pace_tick;
  logic [COUNTWIDTH-1:0] index_inc;

  assign start_rise = bus.start_InHigh & ~start_q;
  assign index_inc  = index_q + COUNTWIDTH'(1);

  fibo_pace_timer #(
    .PACE_CYCLES (PACE_CYCLES),
    .PACEWIDTH   (PACEWIDTH)
  ) u_pace (
    .clk  (SC_RegFIXED_CLOCK_50),
    .rst  (SC_RegFIXED_RESET_InHigh),
    .clr  (state_q == S_LOAD),
    .en   (state_q == S_WAIT_PACE),
    .tick (pace_tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    index_d  = index_q;
    case (state_q)
      S_IDLE, S_DONE, S_OVF: begin
        // Finished states hold their outputs until a fresh start edge
        if (start_rise) begin
          target_d = bus.n_target_InBUS;
          state_d  = S_LOAD;
        end else begin
          state_d  = state_q;
        end
      end
      S_LOAD: begin
        index_d = '0;
        if (target_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_PACE;
        end
      end
      S_WAIT_PACE: begin
        if (pace_tick) begin
          state_d = S_STEP;
        end else begin
          state_d = S_WAIT_PACE;
        end
      end
      S_STEP: begin
        // The sum would not fit: abort without shifting or counting
        if (bus.carry_In) begin
          state_d = S_OVF;
        end else begin
          index_d = index_inc;
          if (index_inc == target_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_PACE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they match a Moore decode of state_q
  always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
    if (SC_RegFIXED_RESET_InHigh) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      index_q     <= '0;
      start_q     <= 1'b0;
      load_seed_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      index_q     <= index_d;
      start_q     <= bus.start_InHigh;
      load_seed_q <= (state_d == S_LOAD);
      busy_q      <= (state_d == S_LOAD) | (state_d == S_WAIT_PACE) | (state_d == S_STEP);
      done_q      <= (state_d == S_DONE) | (state_d == S_OVF);
      overflow_q  <= (state_d == S_OVF);
    end
  end

  assign bus.load_seed_Out = load_seed_q;
  assign bus.shift_Out     = (state_q == S_STEP) & ~bus.carry_In;
  assign bus.busy_Out      = busy_q;
  assign bus.done_Out      = done_q;
  assign bus.overflow_Out  = overflow_q;
  assign bus.index_OutBUS  = index_q;

endmodule

// File: tb/tb_fibo_sequencer_ctrl.sv
// Directed bench for fibo_sequencer_ctrl with a small pace window and an
// 8-bit Fibonacci datapath model (seeds RegA=0, RegB=1).
module tb_fibo_sequencer_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fibo_sequencer_ctrl_if #(.COUNTWIDTH(5)) bus ();

  fibo_sequencer_ctrl #(
    .DATAWIDTH_BUS (8),
    .COUNTWIDTH    (5),
    .PACE_CYCLES   (2),
    .PACEWIDTH     (2)
  ) dut (
    .SC_RegFIXED_CLOCK_50     (clk),
    .SC_RegFIXED_RESET_InHigh (rst),
    .bus                      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [8:0] sum;
  assign sum          = {1'b0, reg_a} + {1'b0, reg_b};
  assign bus.carry_In = sum[8];

  always @(posedge clk) begin
    if (bus.load_seed_Out) begin
      reg_a <= 8'd0;
      reg_b <= 8'd1;
    end else if (bus.shift_Out) begin
      reg_a <= reg_b;
      reg_b <= sum[7:0];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] n;
    int hold;
    int glitch;
    int e_idx;
    int e_ovf;
    int e_regb;
    int e_shifts;
    int e_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int  loads, shifts, badsp, load_c, done_c, prev;
    bit  fin;
    loads = 0; shifts = 0; badsp = 0; load_c = -1; done_c = -1; prev = -1; fin = 1'b0;
    @(negedge clk);
    bus.n_target_InBUS = v.n;
    bus.start_InHigh   = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (bus.load_seed_Out) begin
        loads++;
        if (load_c < 0) load_c = c;
      end
      if (bus.shift_Out) begin
        if (prev >= 0 && c - prev != 3) badsp++;
        prev = c;
        shifts++;
      end
      if (bus.done_Out && done_c < 0) done_c = c;
      if (c == v.hold - 1) bus.start_InHigh = 1'b0;
      if (c == v.glitch) begin
        bus.start_InHigh   = 1'b1;
        bus.n_target_InBUS = 5'd2;
      end else if (c == v.glitch + 1) begin
        bus.start_InHigh = 1'b0;
      end
      if (done_c >= 0 && c >= v.hold - 1 && c > v.glitch + 1) fin = 1'b1;
    end
    chk($sformatf("n%0d finished", v.n), int'(fin), 1);
    chk($sformatf("n%0d load_pulses", v.n), loads, 1);
    chk($sformatf("n%0d shift_pulses", v.n), shifts, v.e_shifts);
    chk($sformatf("n%0d shift_spacing_errs", v.n), badsp, 0);
    chk($sformatf("n%0d load_to_done", v.n), done_c - load_c, v.e_lat);
    chk($sformatf("n%0d index", v.n), int'(bus.index_OutBUS), v.e_idx);
    chk($sformatf("n%0d overflow", v.n), int'(bus.overflow_Out), v.e_ovf);
    chk($sformatf("n%0d busy", v.n), int'(bus.busy_Out), 0);
    chk($sformatf("n%0d regb", v.n), int'(reg_b), v.e_regb);
  endtask

  initial begin
    int shifts_seen, busy_seen, guard;
    checks = 0;
    failures = 0;
    vecs[0] = '{5'd5,  1,  -1, 5,  0, 8,   5,  16};
    vecs[1] = '{5'd0,  1,  -1, 0,  0, 1,   0,  1};
    vecs[2] = '{5'd1,  1,  -1, 1,  0, 1,   1,  4};
    vecs[3] = '{5'd3,  40, -1, 3,  0, 3,   3,  10};
    vecs[4] = '{5'd7,  1,  4,  7,  0, 21,  7,  22};
    vecs[5] = '{5'd20, 1,  -1, 12, 1, 233, 12, 40};
    vecs[6] = '{5'd13, 1,  -1, 12, 1, 233, 12, 40};

    rst = 1'b1;
    bus.start_InHigh   = 1'b0;
    bus.n_target_InBUS = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset load_seed", int'(bus.load_seed_Out), 0);
    chk("reset shift", int'(bus.shift_Out), 0);
    chk("reset busy", int'(bus.busy_Out), 0);
    chk("reset done", int'(bus.done_Out), 0);
    chk("reset overflow", int'(bus.overflow_Out), 0);
    chk("reset index", int'(bus.index_OutBUS), 0);
    rst = 1'b0;

    // Reset asserted in the middle of WAIT_PACE clears outputs immediately
    @(negedge clk);
    bus.n_target_InBUS = 5'd5;
    bus.start_InHigh   = 1'b1;
    @(negedge clk);
    chk("midrst load_seed_before", int'(bus.load_seed_Out), 1);
    bus.start_InHigh = 1'b0;
    @(negedge clk);
    chk("midrst busy_before", int'(bus.busy_Out), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", int'(bus.busy_Out), 0);
    chk("midrst load_seed", int'(bus.load_seed_Out), 0);
    chk("midrst shift", int'(bus.shift_Out), 0);
    chk("midrst done", int'(bus.done_Out), 0);
    @(negedge clk);
    rst = 1'b0;
    shifts_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      shifts_seen += int'(bus.shift_Out);
      busy_seen   += int'(bus.busy_Out);
    end
    chk("post_reset shifts", shifts_seen, 0);
    chk("post_reset busy_cycles", busy_seen, 0);
    chk("post_reset done", int'(bus.done_Out), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // New start edge from OVF: LOAD drops done/overflow, index clears after LOAD
    bus.n_target_InBUS = 5'd1;
    @(negedge clk);
    bus.start_InHigh = 1'b1;
    @(negedge clk);
    chk("restart load_seed", int'(bus.load_seed_Out), 1);
    chk("restart done", int'(bus.done_Out), 0);
    chk("restart overflow", int'(bus.overflow_Out), 0);
    bus.start_InHigh = 1'b0;
    @(negedge clk);
    chk("restart index_cleared", int'(bus.index_OutBUS), 0);
    chk("restart busy", int'(bus.busy_Out), 1);
    guard = 0;
    while (!bus.done_Out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("restart done_reached", int'(bus.done_Out), 1);
    chk("restart index", int'(bus.index_OutBUS), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
